// File: rtl/clock_set_ctrl.sv
// Time-setting controller: debounces mode/inc keys, sequences RUN/SET_HRS/SET_MIN,
// divides clk into seconds ticks and emits field increment pulses. Auto-repeat: CLOCK_SET_AUTOREPEAT_EN.
module clock_set_ctrl #(
    parameter int CLK_HZ        = 1000,
    parameter int DEB_CYCLES    = 20,
    parameter int BLINK_CYCLES  = 500,
    parameter int REPEAT_CYCLES = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic       sec_tick,
    output logic       sec_clr,
    output logic       inc_hrs,
    output logic       inc_min,
    output logic [1:0] mode,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HRS = 2'b01,
        SET_MIN = 2'b10
    } state_t;

    localparam int PW = $clog2(CLK_HZ);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic [1:0]    raw;
    logic [1:0]    deb_lvl_p0;
    logic [1:0]    deb_lvl_p1;
    logic [DW-1:0] deb_cnt [2];
    logic [1:0]    press;
    logic          press_mode;
    logic          press_inc;
    state_t        state;
    state_t        state_next;
    logic          is_set;
    logic          rep_fire;
    logic          inc_hrs_next;
    logic          inc_min_next;
    logic          sec_clr_next;
    logic [PW-1:0] presc;
    logic [BW-1:0] blink_cnt;

    // Stage p0: debounced levels; p1: previous levels for edge detection
    assign raw = {key_inc, key_mode};

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_lvl_p0 <= '0;
            deb_lvl_p1 <= '0;
            for (int k = 0; k < 2; k++) deb_cnt[k] <= '0;
        end else begin
            deb_lvl_p1 <= deb_lvl_p0;
            for (int k = 0; k < 2; k++) begin
                if (raw[k] == deb_lvl_p0[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_LAST) begin
                    deb_lvl_p0[k] <= raw[k];
                    deb_cnt[k]    <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    // A mode press always wins over a simultaneous inc press
    assign press      = deb_lvl_p0 & ~deb_lvl_p1;
    assign press_mode = press[0];
    assign press_inc  = press[1] & ~press[0];
    assign is_set     = (state == SET_HRS) || (state == SET_MIN);

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt;

    assign rep_fire = is_set && deb_lvl_p0[1] && !press[1] && !press_mode && (rep_cnt == REP_LAST);

    always_ff @(posedge clk) begin
        if (rst || !is_set || !deb_lvl_p0[1] || press[1] || press_mode || rep_fire)
            rep_cnt <= '0;
        else
            rep_cnt <= rep_cnt + 1'b1;
    end
`else
    logic unused_repeat;

    // REPEAT_CYCLES only matters when auto-repeat is built in
    assign rep_fire      = 1'b0;
    assign unused_repeat = (REPEAT_CYCLES > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        inc_hrs_next = 1'b0;
        inc_min_next = 1'b0;
        sec_clr_next = 1'b0;
        case (state)
            RUN:     if (press_mode) state_next = SET_HRS;
            SET_HRS: begin
                if (press_mode) state_next = SET_MIN;
                inc_hrs_next = press_inc || rep_fire;
            end
            SET_MIN: begin
                if (press_mode) state_next = RUN;
                inc_min_next = press_inc || rep_fire;
                sec_clr_next = press_mode;
            end
            default: state_next = RUN;
        endcase
    end

    // Stage p2: registered pulse outputs, prescaler and blink phase
    always_ff @(posedge clk) begin
        if (rst) begin
            inc_hrs <= 1'b0;
            inc_min <= 1'b0;
            sec_clr <= 1'b0;
        end else begin
            inc_hrs <= inc_hrs_next;
            inc_min <= inc_min_next;
            sec_clr <= sec_clr_next;
        end
    end

    // Prescaler sits at 0 outside RUN so the first RUN cycle always sees 0
    always_ff @(posedge clk) begin
        if (rst || state != RUN || state_next != RUN)
            presc <= '0;
        else if (presc == PRE_LAST)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    assign sec_tick = (state == RUN) && (presc == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst || state_next != state || state_next == RUN) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: cycle-level behavioural model plus directed key scenarios.
module tb_clock_set_ctrl;

    localparam int CLK_HZ = 10;
    localparam int DEB    = 3;
    localparam int BLINK  = 4;
    localparam int REP    = 8;
`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic       sec_tick, sec_clr, inc_hrs, inc_min, blink;
    logic [1:0] mode;

    clock_set_ctrl #(
        .CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB), .BLINK_CYCLES(BLINK), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst(rst), .key_mode(key_mode), .key_inc(key_inc),
        .sec_tick(sec_tick), .sec_clr(sec_clr), .inc_hrs(inc_hrs), .inc_min(inc_min),
        .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: mode as 0/1/2, cycles since state entry, key sample histories
    bit           armed = 1'b0;
    int           cyc = 0;
    int           m_mode, m_since, m_age;
    bit [1:0]     m_lvl, m_pend;
    bit [DEB-1:0] m_hist [2];
    int           e_tick, e_clr, e_hrs, e_min, e_blink;
    int           n_tick = 0, n_clr = 0, n_hrs = 0, n_min = 0;
    int           tick_q[$], clr_q[$], hrs_q[$];

    always @(posedge clk) begin : model
        bit       pm, pi, rep;
        int       old;
        bit [1:0] raw, nl;
        if (rst) begin
            armed = 1'b1;
            cyc = 1;
            m_mode = 0; m_since = 0; m_age = 0;
            m_lvl = '0; m_pend = '0;
            m_hist[0] = '0; m_hist[1] = '0;
            e_tick = 0; e_clr = 0; e_hrs = 0; e_min = 0; e_blink = 0;
        end else if (armed) begin
            cyc++;
            pm  = m_pend[0];
            pi  = m_pend[1] && !pm;
            old = m_mode;
            if (pm || m_pend[1] || !m_lvl[1] || old == 0) m_age = 0;
            else m_age++;
            rep = REPEAT_EN && (m_age > 0) && (m_age % REP == 0);
            e_hrs = int'(old == 1 && (pi || rep));
            e_min = int'(old == 2 && (pi || rep));
            e_clr = int'(pm && old == 2);
            if (pm) begin
                m_mode  = (old + 1) % 3;
                m_since = 0;
            end else begin
                m_since++;
            end
            e_tick  = int'(m_mode == 0 && (m_since % CLK_HZ) == CLK_HZ - 1);
            e_blink = int'(m_mode != 0 && ((m_since / BLINK) % 2) == 1);
            raw = {key_inc, key_mode};
            for (int k = 0; k < 2; k++) begin
                m_hist[k] = {m_hist[k][DEB-2:0], raw[k]};
                nl[k] = (m_hist[k] == {DEB{~m_lvl[k]}}) ? ~m_lvl[k] : m_lvl[k];
            end
            m_pend = nl & ~m_lvl;
            m_lvl  = nl;
        end
        #1;
        if (armed) begin
            check("sec_tick", int'(sec_tick), e_tick);
            check("sec_clr",  int'(sec_clr),  e_clr);
            check("inc_hrs",  int'(inc_hrs),  e_hrs);
            check("inc_min",  int'(inc_min),  e_min);
            check("mode",     int'(mode),     m_mode);
            check("blink",    int'(blink),    e_blink);
            if (sec_tick) begin n_tick++; tick_q.push_back(cyc); end
            if (sec_clr)  begin n_clr++;  clr_q.push_back(cyc);  end
            if (inc_hrs)  begin n_hrs++;  hrs_q.push_back(cyc);  end
            if (inc_min)  n_min++;
        end
    end

    task automatic wait_mode(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (int'(mode) == target) break;
            @(negedge clk);
        end
        check(name, int'(mode), target);
    endtask

    task automatic tap_mode();
        key_mode = 1'b1;
        repeat (5) @(negedge clk);
        key_mode = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin : scenario
        int h0, m0, c0;
        // Reset then idle: ticks in RUN cycles 10, 20, 30
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (35) @(negedge clk);
        check("idle_tick_count", tick_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check("idle_tick_cycle", (tick_q.size() > i) ? tick_q[i] : -1, 10 * (i + 1));
        check("idle_mode", int'(mode), 0);
        check("idle_other_pulses", n_clr + n_hrs + n_min, 0);

        // Bouncing mode key: one press, blink 0000 then 1111
        key_mode = 1'b1; @(negedge clk);
        key_mode = 1'b0; @(negedge clk);
        key_mode = 1'b1;
        wait_mode(1, 12, "enter_set_hrs");
        for (int i = 0; i < 8; i++) begin
            check("blink_phase", int'(blink), int'(i >= 4));
            @(negedge clk);
        end
        key_mode = 1'b0;
        repeat (5) @(negedge clk);
        check("single_press_mode", int'(mode), 1);

        // SET_MIN: short inc press, then back to RUN with sec_clr
        tap_mode();
        check("enter_set_min", int'(mode), 2);
        h0 = n_hrs; m0 = n_min;
        key_inc = 1'b1;
        repeat (3) @(negedge clk);
        key_inc = 1'b0;
        repeat (6) @(negedge clk);
        check("set_min_inc_min", n_min - m0, 1);
        check("set_min_inc_hrs", n_hrs - h0, 0);
        tick_q.delete(); clr_q.delete();
        c0 = n_clr;
        tap_mode();
        repeat (10) @(negedge clk);
        check("back_to_run", int'(mode), 0);
        check("sec_clr_count", n_clr - c0, 1);
        // sec_clr is RUN cycle 1, the first tick lands in RUN cycle 10
        check("clr_to_tick", (tick_q.size() > 0 && clr_q.size() > 0) ? tick_q[0] - clr_q[0] : -1, CLK_HZ - 1);

        // Coincident presses in SET_HRS: mode wins, inc dropped
        tap_mode();
        check("coincide_pre_mode", int'(mode), 1);
        h0 = n_hrs; m0 = n_min;
        key_mode = 1'b1; key_inc = 1'b1;
        repeat (5) @(negedge clk);
        key_mode = 1'b0; key_inc = 1'b0;
        repeat (5) @(negedge clk);
        check("coincide_mode", int'(mode), 2);
        check("coincide_inc_hrs", n_hrs - h0, 0);
        check("coincide_inc_min", n_min - m0, 0);

        // Long hold in SET_HRS
        tap_mode();
        tap_mode();
        check("hold_pre_mode", int'(mode), 1);
        h0 = n_hrs; m0 = n_min;
        hrs_q.delete();
        key_inc = 1'b1;
        repeat (30) @(negedge clk);
        key_inc = 1'b0;
        repeat (6) @(negedge clk);
        check("hold_inc_count", n_hrs - h0, REPEAT_EN ? 4 : 1);
        check("hold_inc_min", n_min - m0, 0);
        for (int i = 1; i < hrs_q.size(); i++)
            check("repeat_gap", hrs_q[i] - hrs_q[i-1], REP);

        // Reset while setting with the inc key held
        key_inc = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        h0 = n_hrs; m0 = n_min; c0 = n_clr;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_mode", int'(mode), 0);
        repeat (10) @(negedge clk);
        key_inc = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mode_after", int'(mode), 0);
        check("rst_no_inc", (n_hrs - h0) + (n_min - m0), 0);
        check("rst_no_clr", n_clr - c0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
